// File: rtl/scan_pattern_controller_pkg.sv
// scan_ctrl_pkg: state encoding, LFSR/MISR constants and the LFSR step shared by the scan sequencer.
package scan_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} scan_state_t;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction
endpackage

// File: rtl/scan_pattern_controller_if.sv
// scan_pattern_controller_if: control, status and scan-chain signals of the scan sequencer.
interface scan_pattern_controller_if #(
    parameter int NUM_CHAINS = 7,
    parameter int MISR_W     = 32
);
    logic                  start;
    logic [15:0]           num_patterns;
    logic [31:0]           seed;
    logic [MISR_W-1:0]     expected_sig;
    logic [NUM_CHAINS-1:0] SO;
    logic [NUM_CHAINS-1:0] SI;
    logic                  scan_en;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [MISR_W-1:0]     signature;
    logic [15:0]           pattern_cnt;
    modport master (
        output start, num_patterns, seed, expected_sig, SO,
        input  SI, scan_en, busy, done, pass, signature, pattern_cnt
    );
    modport slave (
        input  start, num_patterns, seed, expected_sig, SO,
        output SI, scan_en, busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/scan_pattern_controller_misr.sv
// scan_misr: multiple-input signature register compacting scan-out data.
module scan_misr import scan_ctrl_pkg::*; #(
    parameter int               WIDTH = 32,
    parameter int               IN_W  = 7,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY[WIDTH-1:0]
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             clear,
    input  logic             en,
    input  logic [IN_W-1:0]  d,
    output logic [WIDTH-1:0] sig
);
    logic [WIDTH-1:0] r_sig;
    always_ff @(posedge CK) begin
        if (RST || clear) r_sig <= '0;
        else if (en) r_sig <= (r_sig << 1) ^ (r_sig[WIDTH-1] ? POLY : '0) ^ WIDTH'(d);
    end
    assign sig = r_sig;
endmodule

// File: rtl/scan_pattern_controller.sv
// scan_pattern_controller: LFSR-driven load/capture/unload scan sequencer with MISR signature check.
module scan_pattern_controller import scan_ctrl_pkg::*; #(
    parameter int NUM_CHAINS     = 7,
    parameter int CHAIN_LEN      = 32,
    parameter int CAPTURE_CYCLES = 1,
    parameter int MISR_W         = 32
) (
    input  logic                     CK,
    input  logic                     RST,
    scan_pattern_controller_if.slave bus
);
    localparam int CNT_MAX = CHAIN_LEN > CAPTURE_CYCLES ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_t           r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_num, r_pat_cnt;
    logic [31:0]           r_lfsr, w_lfsr_d, w_seed;
    logic [MISR_W-1:0]     r_exp, w_sig;
    logic [NUM_CHAINS-1:0] r_si;
    logic                  r_scan_en, r_busy, r_done, r_pass;
    logic                  w_start, w_last_load, w_last_cap, w_more, w_misr_en;

    assign w_start     = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_seed      = bus.seed == 32'h0 ? 32'h1 : bus.seed;
    assign w_last_load = r_cnt == CNT_W'(CHAIN_LEN - 1);
    assign w_last_cap  = r_cnt == CNT_W'(CAPTURE_CYCLES - 1);
    assign w_more      = {1'b0, r_pat_cnt} + 17'd1 < {1'b0, r_num};
    // The first load has no prior response in the chains, so only later loads feed the MISR.
    assign w_misr_en   = (r_state == LOAD && r_pat_cnt != 16'd0) || r_state == UNLOAD;
    assign w_lfsr_d    = w_start ? w_seed : r_state == LOAD ? lfsr_step(r_lfsr) : r_lfsr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_next = bus.num_patterns == 16'd0 ? DONE : LOAD;
            LOAD:       if (w_last_load) w_next = CAPTURE;
            CAPTURE:    if (w_last_cap) w_next = w_more ? LOAD : UNLOAD;
            UNLOAD:     if (w_last_load) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_num     <= '0;
            r_pat_cnt <= '0;
            r_lfsr    <= 32'h1;
            r_exp     <= '0;
            r_si      <= '0;
            r_scan_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_start || w_next != r_state || r_state == IDLE || r_state == DONE) ? '0 : r_cnt + 1'b1;
            r_lfsr    <= w_lfsr_d;
            r_si      <= w_next == LOAD ? w_lfsr_d[NUM_CHAINS-1:0] : '0;
            r_scan_en <= w_next == LOAD || w_next == UNLOAD;
            r_busy    <= w_next == LOAD || w_next == CAPTURE || w_next == UNLOAD;
            // Compare one cycle after entering DONE so the last unload sample is in the signature.
            r_done    <= r_state == DONE && !w_start;
            r_pass    <= r_state == DONE && !w_start && w_sig == r_exp;
            if (w_start) begin
                r_num     <= bus.num_patterns;
                r_exp     <= bus.expected_sig;
                r_pat_cnt <= '0;
            end else if (r_state == CAPTURE && w_last_cap) begin
                r_pat_cnt <= r_pat_cnt + 16'd1;
            end
        end
    end

    scan_misr #(
        .WIDTH (MISR_W),
        .IN_W  (NUM_CHAINS),
        .POLY  (MISR_POLY[MISR_W-1:0])
    ) u_misr (
        .CK    (CK),
        .RST   (RST),
        .clear (w_start),
        .en    (w_misr_en),
        .d     (bus.SO),
        .sig   (w_sig)
    );

    assign bus.SI          = r_si;
    assign bus.scan_en     = r_scan_en;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.signature   = w_sig;
    assign bus.pattern_cnt = r_pat_cnt;
endmodule

// File: tb/tb_scan_pattern_controller.sv
// tb_scan_pattern_controller: directed checks of the scan sequencer against a loopback chain and reference MISR.
module tb_scan_pattern_controller;
    localparam int NC = 7;
    localparam int CL = 32;
    localparam int CC = 1;
    localparam int MW = 32;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    always #5 CK = ~CK;

    scan_pattern_controller_if #(.NUM_CHAINS(NC), .MISR_W(MW)) bus ();

    scan_pattern_controller #(
        .NUM_CHAINS     (NC),
        .CHAIN_LEN      (CL),
        .CAPTURE_CYCLES (CC),
        .MISR_W         (MW)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Stand-in scan chains: shift SI in at the head while scan_en, invert contents on capture.
    logic [NC-1:0][CL-1:0] ch = '0;
    always @(posedge CK)
        for (int i = 0; i < NC; i++)
            if (bus.scan_en) ch[i] <= {ch[i][CL-2:0], bus.SI[i]};
            else if (bus.busy) ch[i] <= ~ch[i];
    always_comb for (int i = 0; i < NC; i++) bus.SO[i] = ch[i][CL-1];

    logic se_seen, si_bad;
    always @(posedge CK) begin
        if (bus.scan_en) se_seen = 1'b1;
        if (bus.busy && !bus.scan_en && bus.SI != '0) si_bad = 1'b1;
    end

    int n_checks = 0;
    int n_errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] mstep(input logic [31:0] s, input logic [NC-1:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {25'h0, d};
    endfunction

    // Behavioural reference: pass n<p loads pattern n, pass n==p is the final unload.
    function automatic logic [31:0] ref_sig(input logic [31:0] seed, input int p);
        logic [CL-1:0] c [NC];
        logic [31:0]   l;
        logic [31:0]   s;
        logic [NC-1:0] so;
        l = seed == 32'h0 ? 32'h1 : seed;
        s = 32'h0;
        for (int i = 0; i < NC; i++) c[i] = '0;
        for (int n = 0; n <= p; n++) begin
            for (int k = 0; k < CL; k++) begin
                for (int i = 0; i < NC; i++) so[i] = c[i][CL-1];
                if (n > 0) s = mstep(s, so);
                for (int i = 0; i < NC; i++) c[i] = {c[i][CL-2:0], n < p ? l[i] : 1'b0};
                if (n < p) l = lstep(l);
            end
            if (n < p) for (int q = 0; q < CC; q++) for (int i = 0; i < NC; i++) c[i] = ~c[i];
        end
        return s;
    endfunction

    int            cyc;
    logic          first_se;
    logic [NC-1:0] first_si;

    task automatic run(input logic [15:0] p, input logic [31:0] s, input logic [31:0] e,
                       input int poke_at, input logic [15:0] poke_p);
        @(negedge CK);
        bus.start = 1'b1; bus.num_patterns = p; bus.seed = s; bus.expected_sig = e;
        se_seen = 1'b0; si_bad = 1'b0;
        @(negedge CK);
        bus.start = 1'b0;
        first_se = bus.scan_en;
        first_si = bus.SI;
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            bus.start        = cyc == poke_at;
            bus.num_patterns = cyc == poke_at ? poke_p : p;
            bus.seed         = cyc == poke_at ? 32'hDEAD_0001 : s;
            bus.expected_sig = cyc == poke_at ? ~e : e;
            @(negedge CK);
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    logic [31:0] exp1, exp3, exp2, exp_s1;

    initial begin
        bus.start = 1'b0; bus.num_patterns = '0; bus.seed = '0; bus.expected_sig = '0;
        repeat (3) begin
            @(negedge CK);
            bus.start        = 1'($urandom);
            bus.num_patterns = 16'($urandom);
            bus.seed         = $urandom;
            bus.expected_sig = $urandom;
        end
        check("rst_scan_en", bus.scan_en, 0);
        check("rst_si", bus.SI, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_sig", bus.signature, 0);
        check("rst_pcnt", bus.pattern_cnt, 0);
        RST = 1'b0; bus.start = 1'b0;

        run(16'd0, 32'h0, 32'h0, -1, 16'd0);
        check("p0_cycles", cyc, 1);
        check("p0_pass", bus.pass, 1);
        check("p0_scan_en_seen", se_seen, 0);

        exp1 = ref_sig(32'hACE1, 1);
        run(16'd1, 32'hACE1, exp1, -1, 16'd0);
        check("p1_cycles", cyc, 66);
        check("p1_first_scan_en", first_se, 1);
        check("p1_first_si", first_si, 7'h61);
        check("p1_sig", bus.signature, exp1);
        check("p1_pass", bus.pass, 1);
        check("p1_pcnt", bus.pattern_cnt, 1);
        check("p1_busy_done", bus.busy, 0);
        check("p1_capture_si", si_bad, 0);
        run(16'd1, 32'hACE1, exp1 ^ 32'h0000_0100, -1, 16'd0);
        check("p1_bad_pass", bus.pass, 0);
        check("p1_bad_sig", bus.signature, exp1);

        exp3 = ref_sig(32'h1234_5678, 3);
        run(16'd3, 32'h1234_5678, exp3, -1, 16'd0);
        check("p3_cycles", cyc, 132);
        check("p3_sig", bus.signature, exp3);
        check("p3_pcnt", bus.pattern_cnt, 3);
        check("p3_pass", bus.pass, 1);

        exp2 = ref_sig(32'h0000_BEEF, 2);
        run(16'd2, 32'h0000_BEEF, exp2, 5, 16'd5);
        check("poke_cycles", cyc, 99);
        check("poke_sig", bus.signature, exp2);
        check("poke_pcnt", bus.pattern_cnt, 2);
        check("poke_pass", bus.pass, 1);

        @(negedge CK);
        bus.start = 1'b1; bus.num_patterns = 16'd1; bus.seed = 32'h7;
        @(negedge CK);
        bus.start = 1'b0;
        repeat (9) @(negedge CK);
        check("mid_load_scan_en", bus.scan_en, 1);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        check("mid_rst_scan_en", bus.scan_en, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sig", bus.signature, 0);

        exp_s1 = ref_sig(32'h1, 2);
        run(16'd2, 32'h0, exp_s1, -1, 16'd0);
        check("seed0_first_si", first_si, 7'h01);
        check("seed0_cycles", cyc, 99);
        check("seed0_sig", bus.signature, exp_s1);
        check("seed0_pass", bus.pass, 1);
        run(16'd2, 32'h1, exp_s1, -1, 16'd0);
        check("seed1_sig", bus.signature, exp_s1);
        check("seed1_pass", bus.pass, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scan_pattern_controller.md
# scan_pattern_controller

Parametrised, synthesizable scan-test sequencer for multi-chain scan-inserted designs such as the 7-chain `s9234_scan`. It generates pseudo-random scan-in data from an LFSR and drives `scan_en` through load/capture/unload phases for a programmed number of patterns. Scan-out data is compacted into a MISR, and the final signature is compared against a golden value. It replaces per-cycle output-XOR comparison in testbenches with on-chip, chain-count- and length-agnostic BIST-style control.

## Interface
Parameters:
- `NUM_CHAINS`, 7, number of scan chains; legal range 1..32
- `CHAIN_LEN`, 32, flops in the longest chain; shorter chains are padded at the head; ≥ 2
- `CAPTURE_CYCLES`, 1, functional-clock cycles per pattern with `scan_en`=0; ≥ 1
- `MISR_W`, 32, signature width; must satisfy `MISR_W` ≥ `NUM_CHAINS`

Ports:
- `CK`  in  1  single clock, rising edge; DUT uses the same clock
- `RST`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; accepted only in IDLE or DONE
- `num_patterns`  in  16  pattern count P, sampled with `start`
- `seed`  in  32  LFSR seed, sampled with `start`; 0 is replaced by 32'h1
- `expected_sig`  in  MISR_W  golden signature, sampled with `start`
- `SO`  in  NUM_CHAINS  chain outputs from the DUT
- `SI`  out  NUM_CHAINS  chain inputs to the DUT
- `scan_en`  out  1  DUT scan-mode select
- `busy`  out  1  high from LOAD through UNLOAD
- `done`  out  1  level; high in DONE until the next accepted start or `RST`
- `pass`  out  1  valid while `done`=1; 1 means signature == `expected_sig`
- `signature`  out  MISR_W  current MISR contents
- `pattern_cnt`  out  16  patterns captured so far

## Operation
- States: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE/DONE, `start`=1:
  - latch P, seed, and `expected_sig`
  - clear the MISR, `pattern_cnt`, and the shift counter
  - if P=0, go to DONE; otherwise go to LOAD
- LOAD: `scan_en`=1 for `CHAIN_LEN` cycles.
  - Each cycle the LFSR steps once and `SI[i]` = `lfsr[i]`.
  - For pattern index ≥ 1, the MISR absorbs `SO` each cycle; this unloads the previous response.
  - For the first pattern, `SO` is ignored because chain contents are unknown.
  - After `CHAIN_LEN` cycles, go to CAPTURE.
- CAPTURE: `scan_en`=0 and `SI`=0 for `CAPTURE_CYCLES` cycles.
  - `pattern_cnt` increments on the last capture cycle.
  - If `pattern_cnt`+1 < P, go to LOAD; otherwise go to UNLOAD.
- UNLOAD: `scan_en`=1 and `SI`=0 for `CHAIN_LEN` cycles; the MISR absorbs `SO` each cycle. Then go to DONE.
- DONE: `done`=1, `busy`=0. `pass` is registered on entry.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps 32'h80200003); it steps only in LOAD.
- MISR update: next = (sig << 1) ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extend(`SO`). `MISR_POLY` defaults to 32'h04C11DB7, truncated to `MISR_W`.
- A `start` received while `busy`=1 is ignored and has no side effects.

## Timing
- Reset values (the cycle after `RST` is sampled high):
  - state IDLE
  - `scan_en`, `SI`, `busy`, `done`, `pass` = 0
  - `signature` = 0, `pattern_cnt` = 0
  - LFSR = 32'h1
- `RST` mid-operation: the state returns to IDLE with `scan_en`=0 on that edge. The DUT chain contents are not restored.
- `start` sampled at edge 0: `scan_en` is first high in the cycle after edge 0.
- `done` rises after edge 0 + P·(`CHAIN_LEN`+`CAPTURE_CYCLES`) + `CHAIN_LEN` + 1. For P=0, it rises after edge 1.
- `SO` is sampled on the same edge on which the DUT shifts, i.e. the value present before that edge.
- The MISR absorbs exactly P·`CHAIN_LEN` `SO` samples.
- All outputs are registered; there is no combinational path from `SO` to any output.

## Structure
- Package `scan_ctrl_pkg` holds:
  - the state enum `scan_state_t`
  - the `LFSR_TAPS` and `MISR_POLY` constants
  - the `lfsr_step` function
- Sub-module `scan_misr` is parametrised by `WIDTH`, `IN_W`, and `POLY`, with ports `CK`, `RST`, `clear`, `en`, `d`, `sig`.
- The top level holds the FSM, counters, LFSR, and compare logic.

## Test plan
- Reset: hold `RST` 3 cycles with random inputs. Then all outputs are 0, `scan_en`=0, and state is IDLE.
- P=0, `expected_sig`=0, `start`: `done`=1 and `pass`=1 after 1 edge; `scan_en` never rises.
- Default parameters, P=1, seed 32'hACE1:
  - Wire `SO` to a 7×32 shift-register model that loopbacks `SI`, with a capture function that inverts contents.
  - `done` after 66 cycles.
  - The signature equals the reference-model MISR.
  - `pass`=1 with the model's golden value and 0 when one bit is flipped.
- P=3 against the real `s9234_scan` vs a golden run: signatures are equal, and `pattern_cnt`=3 at `done`.
- `start` pulsed mid-LOAD with different `num_patterns`: ignored; the run completes with the original P.
- `RST` at LOAD cycle 10: `scan_en`=0 the next cycle. A following `start` with seed 0 behaves identically to seed 1.
